// File: rtl/uart_mmio.sv
// uart_mmio: MMIO register block for the core's UART/counter window.
// It holds a one-byte TX register and a one-byte RX buffer in front of
// the UART ready/valid ports. It also keeps free-running cycle and
// retired-instruction counters, and returns registered load data.
module uart_mmio #(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_read,
  input  logic        uart_write,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready
);

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_CYCLE  = 8'h10;
  localparam logic [7:0] ADDR_INST   = 8'h14;
  localparam logic [7:0] ADDR_CNTRST = 8'h18;

  typedef enum logic {
    TX_IDLE,
    TX_PENDING
  } txState_e;

  txState_e             txState_q, txState_d;
  logic [7:0]           txBuf_q, txBuf_d;
  logic                 rxFull_q, rxFull_d;
  logic [7:0]           rxBuf_q, rxBuf_d;
  logic [CNT_WIDTH-1:0] cycleCnt_q, cycleCnt_d;
  logic [CNT_WIDTH-1:0] instCnt_q, instCnt_d;
  logic [31:0]          rdata_q, rdata_d;

  logic txPending;
  logic txStore;
  logic rxCapture;
  logic rxClearRead;
  logic cntClear;
  logic unusedWdata;

  // Only the low byte of store data is architecturally meaningful.
  assign unusedWdata = ^wdata[31:8];

  assign txPending   = (txState_q == TX_PENDING);
  assign txStore     = uart_write && (addr == ADDR_TXDATA);
  assign rxCapture   = uart_rx_data_out_valid && !rxFull_q;
  assign rxClearRead = uart_read && (addr == ADDR_RXDATA) && rxFull_q;
  assign cntClear    = uart_write && (addr == ADDR_CNTRST);

  assign uart_tx_data_in_valid  = txPending;
  assign uart_tx_data_in        = txBuf_q;
  assign uart_rx_data_out_ready = !rxFull_q;
  assign rdata                  = rdata_q;

  // TX holding register: a store is accepted only while idle, and the
  // byte is released once the UART takes it. Stores that land while a
  // byte is pending (including the handshake cycle) are dropped.
  always_comb begin
    txState_d = txState_q;
    txBuf_d   = txBuf_q;
    case (txState_q)
      TX_IDLE: begin
        if (txStore) begin
          txState_d = TX_PENDING;
          txBuf_d   = wdata[7:0];
        end
      end
      TX_PENDING: begin
        if (uart_tx_data_in_ready) begin
          txState_d = TX_IDLE;
        end
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  // RX buffer: capture and clearing read never coincide because ready
  // is low whenever the buffer is full.
  always_comb begin
    rxFull_d = rxFull_q;
    rxBuf_d  = rxBuf_q;
    if (rxCapture) begin
      rxFull_d = 1'b1;
      rxBuf_d  = uart_rx_data_out;
    end else if (rxClearRead) begin
      rxFull_d = 1'b0;
    end
  end

  // Counters wrap naturally; a counter-reset store overrides that
  // cycle's increment.
  always_comb begin
    cycleCnt_d = cycleCnt_q + CNT_WIDTH'(1);
    instCnt_d  = instCnt_q + CNT_WIDTH'(inst_retire);
    if (cntClear) begin
      cycleCnt_d = '0;
      instCnt_d  = '0;
    end
  end

  // Load data mux: samples pre-edge state and holds between loads.
  always_comb begin
    rdata_d = rdata_q;
    if (uart_read) begin
      case (addr)
        ADDR_STATUS: rdata_d = {30'b0, rxFull_q, !txPending};
        ADDR_RXDATA: rdata_d = {24'b0, rxBuf_q};
        ADDR_CYCLE:  rdata_d = 32'(cycleCnt_q);
        ADDR_INST:   rdata_d = 32'(instCnt_q);
        default:     rdata_d = 32'b0;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txState_q  <= TX_IDLE;
      txBuf_q    <= 8'h00;
      rxFull_q   <= 1'b0;
      rxBuf_q    <= 8'h00;
      cycleCnt_q <= '0;
      instCnt_q  <= '0;
      rdata_q    <= 32'b0;
    end else begin
      txState_q  <= txState_d;
      txBuf_q    <= txBuf_d;
      rxFull_q   <= rxFull_d;
      rxBuf_q    <= rxBuf_d;
      cycleCnt_q <= cycleCnt_d;
      instCnt_q  <= instCnt_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed scoreboard bench for uart_mmio.
// Load expectations are queued when a read is issued and popped by a
// monitor once the registered load data appears. A second 8-bit counter
// instance shares all inputs so that counter wrap can be observed.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_read;
  logic        uart_write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        inst_retire;
  logic [31:0] rdata;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;

  logic [31:0] rdata8;
  logic        rxReady8;
  logic [7:0]  txData8;
  logic        txValid8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] exp;
    bit          chk8;
    logic [31:0] exp8;
    string       name;
  } rdExp_t;

  rdExp_t sb[$];
  logic   rdValid = 1'b0;
  int     hsCount = 0;
  logic [7:0] hsByte = 8'h00;

  uart_mmio #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .uart_read(uart_read), .uart_write(uart_write),
    .addr(addr), .wdata(wdata), .inst_retire(inst_retire), .rdata(rdata),
    .uart_rx_data_out(rxData), .uart_rx_data_out_valid(rxValid),
    .uart_rx_data_out_ready(rxReady), .uart_tx_data_in(txData),
    .uart_tx_data_in_valid(txValid), .uart_tx_data_in_ready(txReady)
  );

  uart_mmio #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .uart_read(uart_read), .uart_write(uart_write),
    .addr(addr), .wdata(wdata), .inst_retire(inst_retire), .rdata(rdata8),
    .uart_rx_data_out(rxData), .uart_rx_data_out_valid(rxValid),
    .uart_rx_data_out_ready(rxReady8), .uart_tx_data_in(txData8),
    .uart_tx_data_in_valid(txValid8), .uart_tx_data_in_ready(txReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, actual, expected);
    end
  endtask

  // One bus cycle: inputs are driven after a falling edge and held
  // across the following rising edge. For reads, d is the expected data.
  task automatic applyStimulus(input bit isRead, input logic [7:0] a,
                               input logic [31:0] d, input string name,
                               input bit chk8 = 1'b0,
                               input logic [31:0] exp8 = 32'h0);
    rdExp_t e;
    addr = a;
    if (isRead) begin
      uart_read = 1'b1;
      e.exp = d; e.chk8 = chk8; e.exp8 = exp8; e.name = name;
      sb.push_back(e);
    end else begin
      uart_write = 1'b1;
      wdata = d;
    end
    @(negedge clk);
    uart_read  = 1'b0;
    uart_write = 1'b0;
    wdata      = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Flags the cycle after each load so the monitor knows rdata is fresh.
  always @(posedge clk) rdValid <= uart_read;

  // Records every TX handshake seen on the main instance.
  always @(posedge clk) begin
    if (txValid && txReady) begin
      hsCount++;
      hsByte = txData;
    end
  end

  // Scoreboard monitor: pops one expectation per completed load.
  always @(negedge clk) begin
    if (rdValid) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'h1, 32'h0);
      end else begin
        rdExp_t e;
        e = sb.pop_front();
        checkOutput(e.name, rdata, e.exp);
        if (e.chk8) checkOutput({e.name, "_w8"}, rdata8, e.exp8);
      end
    end
  end

  initial begin
    rst_n = 1'b0; uart_read = 1'b0; uart_write = 1'b0; addr = 8'h00;
    wdata = 32'h0; inst_retire = 1'b0; rxData = 8'h00; rxValid = 1'b0;
    txReady = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_txValid", {31'b0, txValid}, 32'h0);
    checkOutput("rst_txData", {24'b0, txData}, 32'h0);
    checkOutput("rst_rxReady", {31'b0, rxReady}, 32'h1);
    checkOutput("rst_rdata", rdata, 32'h0);
    applyStimulus(1, 8'h00, 32'h1, "rst_status");

    // TX path with UART not ready
    applyStimulus(0, 8'h08, 32'h41, "tx_store");
    for (int i = 0; i < 5; i++) begin
      checkOutput("tx_valid_hold", {31'b0, txValid}, 32'h1);
      checkOutput("tx_data_hold", {24'b0, txData}, 32'h41);
      @(negedge clk);
    end
    applyStimulus(1, 8'h00, 32'h0, "tx_status_pending");
    applyStimulus(0, 8'h08, 32'h42, "tx_store_drop");
    checkOutput("tx_data_after_drop", {24'b0, txData}, 32'h41);
    // Handshake cycle with a colliding store that must be dropped
    txReady = 1'b1;
    applyStimulus(0, 8'h08, 32'h43, "tx_store_hs");
    txReady = 1'b0;
    checkOutput("tx_valid_done", {31'b0, txValid}, 32'h0);
    checkOutput("tx_hs_count", hsCount, 32'd1);
    checkOutput("tx_hs_byte", {24'b0, hsByte}, 32'h41);
    applyStimulus(1, 8'h00, 32'h1, "tx_status_idle");

    // RX path
    rxData = 8'h5A; rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    checkOutput("rx_ready_full", {31'b0, rxReady}, 32'h0);
    rxData = 8'hA5; rxValid = 1'b1;
    applyStimulus(1, 8'h00, 32'h3, "rx_status_full");
    applyStimulus(1, 8'h04, 32'h5A, "rx_data1");
    checkOutput("rx_ready_after_read", {31'b0, rxReady}, 32'h1);
    applyStimulus(1, 8'h00, 32'h1, "rx_status_cleared");
    rxValid = 1'b0;
    checkOutput("rx_ready_second", {31'b0, rxReady}, 32'h0);
    applyStimulus(1, 8'h04, 32'hA5, "rx_data2");
    applyStimulus(1, 8'h00, 32'h1, "rx_status_empty");
    applyStimulus(1, 8'h04, 32'hA5, "rx_stale");
    applyStimulus(1, 8'h00, 32'h1, "rx_stale_no_effect");

    // Counters: 100 cycles after a counter clear, retire on 40 of them
    applyStimulus(0, 8'h18, 32'hFFFF_FFFF, "cnt_clear");
    for (int i = 0; i < 100; i++) begin
      inst_retire = ((i % 5) < 2);
      @(negedge clk);
    end
    inst_retire = 1'b0;
    applyStimulus(1, 8'h10, 32'd100, "cycle_cnt");
    applyStimulus(1, 8'h14, 32'd40, "inst_cnt");
    applyStimulus(0, 8'h18, 32'h0, "cnt_clear2");
    applyStimulus(1, 8'h10, 32'd0, "cycle_after_clear");
    applyStimulus(1, 8'h14, 32'd0, "inst_after_clear");
    applyStimulus(1, 8'h10, 32'd2, "cycle_counting");

    // Wrap on the 8-bit instance after 260 cycles, and unmapped read
    applyStimulus(0, 8'h18, 32'h0, "cnt_clear3");
    idle(260);
    applyStimulus(1, 8'h10, 32'd260, "cycle_wrap", 1'b1, 32'h4);
    applyStimulus(1, 8'h0C, 32'h0, "unmapped", 1'b1, 32'h0);

    // Reset while TX pending and RX full
    rxData = 8'h33; rxValid = 1'b1;
    applyStimulus(0, 8'h08, 32'h77, "tx_store_pre_rst");
    rxValid = 1'b0;
    checkOutput("pre_rst_txValid", {31'b0, txValid}, 32'h1);
    checkOutput("pre_rst_txData", {24'b0, txData}, 32'h77);
    checkOutput("pre_rst_rxReady", {31'b0, rxReady}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_txValid", {31'b0, txValid}, 32'h0);
    checkOutput("mid_rst_txData", {24'b0, txData}, 32'h0);
    checkOutput("mid_rst_rxReady", {31'b0, rxReady}, 32'h1);
    checkOutput("mid_rst_rdata", rdata, 32'h0);
    txReady = 1'b1;
    idle(3);
    txReady = 1'b0;
    checkOutput("mid_rst_no_tx", hsCount, 32'd1);
    applyStimulus(1, 8'h00, 32'h1, "mid_rst_status");
    applyStimulus(1, 8'h04, 32'h0, "mid_rst_rxbuf");

    idle(2);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
